// File: rtl/cmd_rsp_arbiter.sv
// Round-robin arbiter that serialises N_REQ requesters onto one shared command/response server.
// Optional response watchdog with drain of late server responses: define CMD_RSP_ARB_TIMEOUT_EN.
module cmd_rsp_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_vld,
    output logic [N_REQ-1:0]        req_rdy,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        rsp_vld,
    input  logic [N_REQ-1:0]        rsp_rdy,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    srv_cmd_vld,
    input  logic                    srv_cmd_rdy,
    output logic [DATA_W-1:0]       srv_cmd_data,
    input  logic                    srv_rsp_vld,
    output logic                    srv_rsp_rdy,
    input  logic [DATA_W-1:0]       srv_rsp_data
);
    // Every port pair is valid/ready: a beat transfers on a rising edge where both are 1;
    // a producer holds valid and payload stable until that edge.

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, CMD, RSP, RET} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     ptr, grant, winner;
    logic [GW:0]       scan_idx;
    logic              found;
    logic [DATA_W-1:0] cmd_q, rsp_q;
    logic              drain;

`ifdef CMD_RSP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;
    logic          timeout_hit;

    assign timeout_hit = (state == RSP) && !srv_rsp_vld && (tmo_cnt == TW'(TIMEOUT - 1));
    assign rsp_err     = err_q;
`else
    assign drain   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (GW+1)'(k);
            if (scan_idx >= (GW+1)'(N_REQ)) scan_idx = scan_idx - (GW+1)'(N_REQ);
            if (!found && req_vld[scan_idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_rdy     = '0;
        rsp_vld     = '0;
        srv_cmd_vld = 1'b0;
        srv_rsp_rdy = drain;
        case (state)
            IDLE: begin
                if (found) begin
                    req_rdy[winner] = 1'b1;
                    state_nxt       = CMD;
                end
            end
            CMD: begin
                srv_cmd_vld = !drain;
                if (srv_cmd_rdy && !drain) state_nxt = RSP;
            end
            RSP: begin
                srv_rsp_rdy = 1'b1;
                if (srv_rsp_vld) state_nxt = RET;
`ifdef CMD_RSP_ARB_TIMEOUT_EN
                else if (timeout_hit) state_nxt = RET;
`endif
            end
            RET: begin
                rsp_vld[grant] = 1'b1;
                if (rsp_rdy[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            grant <= '0;
            cmd_q <= '0;
            rsp_q <= '0;
        end else begin
            if (state == IDLE && found) begin
                cmd_q <= req_data[winner*DATA_W +: DATA_W];
                grant <= winner;
            end
            if (state == RSP && srv_rsp_vld) rsp_q <= srv_rsp_data;
`ifdef CMD_RSP_ARB_TIMEOUT_EN
            else if (timeout_hit) rsp_q <= '0;
`endif
            if (state == RET && rsp_rdy[grant])
                ptr <= (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

`ifdef CMD_RSP_ARB_TIMEOUT_EN
    // After a timeout the server still owes one response; swallow it before the next command.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            drain   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state != RSP)      tmo_cnt <= '0;
            else if (!srv_rsp_vld) tmo_cnt <= tmo_cnt + 1'b1;
            if (timeout_hit)                  drain <= 1'b1;
            else if (drain && srv_rsp_vld)    drain <= 1'b0;
            if (timeout_hit)                      err_q <= 1'b1;
            else if (state == RSP && srv_rsp_vld) err_q <= 1'b0;
        end
    end
`endif

    assign srv_cmd_data = cmd_q;
    assign rsp_data     = rsp_q;

endmodule

// File: tb/tb_cmd_rsp_arbiter.sv
// Directed bench for cmd_rsp_arbiter: reset, latency, round robin, stalls, response hold,
// dropped request, mid-transaction reset and (with CMD_RSP_ARB_TIMEOUT_EN) the watchdog.
module tb_cmd_rsp_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [N*W-1:0] req_data;
    logic [W-1:0]   rsp_data, srv_cmd_data, srv_rsp_data;
    logic           rsp_err, srv_cmd_vld, srv_cmd_rdy, srv_rsp_vld, srv_rsp_rdy;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    cmd_rsp_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .srv_cmd_vld(srv_cmd_vld), .srv_cmd_rdy(srv_cmd_rdy), .srv_cmd_data(srv_cmd_data),
        .srv_rsp_vld(srv_rsp_vld), .srv_rsp_rdy(srv_rsp_rdy), .srv_rsp_data(srv_rsp_data)
    );

    wire [26:0] all_outs = {req_rdy, rsp_vld, rsp_data, rsp_err, srv_cmd_vld, srv_cmd_data, srv_rsp_rdy};

    task automatic idle_inputs();
        req_vld = '0; req_data = '0; rsp_rdy = '0;
        srv_cmd_rdy = 1'b0; srv_rsp_vld = 1'b0; srv_rsp_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (all_outs !== 27'd0) begin errors++; $display("FAIL reset_outs cyc=%0d got=%h exp=0", i, all_outs); end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        req_vld = 4'b0001; req_data[7:0] = 8'h5A; srv_cmd_rdy = 1'b1; #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL basic_req_rdy got=%b exp=0001", req_rdy); end
        @(negedge clk);
        req_vld = '0; srv_rsp_vld = 1'b1; srv_rsp_data = 8'h5B; #1;
        checks++; if (srv_cmd_vld !== 1'b1 || srv_cmd_data !== 8'h5A) begin errors++; $display("FAIL basic_cmd got=%b/%h exp=1/5a", srv_cmd_vld, srv_cmd_data); end
        checks++; if (srv_rsp_rdy !== 1'b0) begin errors++; $display("FAIL basic_rsp_rdy_in_cmd got=%b exp=0", srv_rsp_rdy); end
        @(negedge clk); #1;
        checks++; if (srv_rsp_rdy !== 1'b1 || srv_cmd_vld !== 1'b0 || rsp_vld !== 4'b0) begin errors++; $display("FAIL basic_rsp_phase got=%b/%b/%b exp=1/0/0000", srv_rsp_rdy, srv_cmd_vld, rsp_vld); end
        @(negedge clk);
        srv_rsp_vld = 1'b0; rsp_rdy = 4'b0001; #1;
        checks++; if (rsp_vld !== 4'b0001 || rsp_data !== 8'h5B || rsp_err !== 1'b0) begin errors++; $display("FAIL basic_ret got=%b/%h/%b exp=0001/5b/0", rsp_vld, rsp_data, rsp_err); end
        @(negedge clk);
        rsp_rdy = '0; srv_cmd_rdy = 1'b0; #1;
        checks++; if (rsp_vld !== 4'b0 || srv_cmd_vld !== 1'b0) begin errors++; $display("FAIL basic_back_idle got=%b/%b exp=0000/0", rsp_vld, srv_cmd_vld); end
    endtask

    task automatic test_round_robin();
        int g;
        logic [W-1:0] d;
        do_reset();
        @(negedge clk);
        req_data = {8'h40, 8'h30, 8'h20, 8'h10}; req_vld = 4'hF; rsp_rdy = 4'hF;
        srv_cmd_rdy = 1'b1; srv_rsp_vld = 1'b1;
        for (int t = 0; t < 5; t++) begin
            g = t % N;
            d = W'(16 * (g + 1));
            if (t > 0) @(negedge clk);
            #1;
            checks++; if (req_rdy !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, req_rdy, 4'(1 << g)); end
            @(negedge clk);
            srv_rsp_data = d + 8'h01; #1;
            checks++; if (srv_cmd_vld !== 1'b1 || srv_cmd_data !== d) begin errors++; $display("FAIL rr_cmd t=%0d got=%b/%h exp=1/%h", t, srv_cmd_vld, srv_cmd_data, d); end
            @(negedge clk); #1;
            checks++; if (srv_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rr_srv_rsp_rdy t=%0d got=%b exp=1", t, srv_rsp_rdy); end
            @(negedge clk); #1;
            checks++; if (rsp_vld !== 4'(1 << g) || rsp_data !== d + 8'h01) begin errors++; $display("FAIL rr_rsp t=%0d got=%b/%h exp=%b/%h", t, rsp_vld, rsp_data, 4'(1 << g), d + 8'h01); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stall();
        @(negedge clk);
        req_vld = 4'b0010; req_data = 32'h0000_7700; #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL stall_req_rdy got=%b exp=0010", req_rdy); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_vld = '0; req_data = 32'h0000_EE00;
            srv_cmd_rdy = (c == 4); srv_rsp_vld = (c == 7); srv_rsp_data = 8'h78;
            rsp_rdy = (c == 8) ? 4'b0010 : 4'b0000;
            #1;
            if (c <= 4) begin
                checks++; if (srv_cmd_vld !== 1'b1 || srv_cmd_data !== 8'h77) begin errors++; $display("FAIL stall_cmd c=%0d got=%b/%h exp=1/77", c, srv_cmd_vld, srv_cmd_data); end
            end else if (c <= 7) begin
                checks++; if (srv_rsp_rdy !== 1'b1 || srv_cmd_vld !== 1'b0) begin errors++; $display("FAIL stall_rsp c=%0d got=%b/%b exp=1/0", c, srv_rsp_rdy, srv_cmd_vld); end
            end else begin
                checks++; if (rsp_vld !== 4'b0010 || rsp_data !== 8'h78) begin errors++; $display("FAIL stall_ret c=%0d got=%b/%h exp=0010/78", c, rsp_vld, rsp_data); end
            end
            if (c < 8) begin
                checks++; if (rsp_vld !== 4'b0) begin errors++; $display("FAIL stall_early_rsp c=%0d got=%b exp=0000", c, rsp_vld); end
            end
        end
        @(negedge clk);
        idle_inputs(); #1;
        checks++; if (rsp_vld !== 4'b0) begin errors++; $display("FAIL stall_done got=%b exp=0000", rsp_vld); end
    endtask

    task automatic test_rsp_hold();
        @(negedge clk);
        req_vld = 4'b0100; req_data = {8'h00, 8'h22, 8'h11, 8'h00};
        srv_cmd_rdy = 1'b1; srv_rsp_vld = 1'b1; srv_rsp_data = 8'h23; #1;
        checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL hold_first got=%b exp=0100", req_rdy); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_vld = 4'b0110;
            rsp_rdy = (c >= 3 && c <= 6) ? 4'b0010 : ((c == 7) ? 4'b0100 : 4'b0000);
            #1;
            if (c <= 7) begin
                checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL hold_req_rdy c=%0d got=%b exp=0000", c, req_rdy); end
            end else begin
                checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL hold_regrant got=%b exp=0010", req_rdy); end
            end
            if (c >= 3 && c <= 7) begin
                checks++; if (rsp_vld !== 4'b0100 || rsp_data !== 8'h23) begin errors++; $display("FAIL hold_rsp c=%0d got=%b/%h exp=0100/23", c, rsp_vld, rsp_data); end
            end
        end
        @(negedge clk);
        req_vld = '0; srv_rsp_data = 8'h12; #1;
        checks++; if (srv_cmd_data !== 8'h11) begin errors++; $display("FAIL hold_cmd1 got=%h exp=11", srv_cmd_data); end
        @(negedge clk);
        @(negedge clk);
        rsp_rdy = 4'b0010; #1;
        checks++; if (rsp_vld !== 4'b0010 || rsp_data !== 8'h12) begin errors++; $display("FAIL hold_rsp1 got=%b/%h exp=0010/12", rsp_vld, rsp_data); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_drop();
        @(negedge clk);
        req_vld = 4'b0001; req_data[7:0] = 8'h3C; srv_cmd_rdy = 1'b1; srv_rsp_vld = 1'b1; srv_rsp_data = 8'h3D; #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL drop_first got=%b exp=0001", req_rdy); end
        @(negedge clk);
        req_vld = 4'b1000; #1;
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0000", req_rdy); end
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        rsp_rdy = 4'b0001; #1;
        checks++; if (rsp_vld !== 4'b0001 || rsp_data !== 8'h3D) begin errors++; $display("FAIL drop_rsp got=%b/%h exp=0001/3d", rsp_vld, rsp_data); end
        @(negedge clk);
        rsp_rdy = '0; #1;
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL drop_idle got=%b exp=0000", req_rdy); end
        @(negedge clk); #1;
        checks++; if (srv_cmd_vld !== 1'b0 || rsp_vld !== 4'b0) begin errors++; $display("FAIL drop_no_grant got=%b/%b exp=0/0000", srv_cmd_vld, rsp_vld); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_vld = 4'b1000; req_data[31:24] = 8'h99; srv_cmd_rdy = 1'b1; #1;
        checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL rmid_grant got=%b exp=1000", req_rdy); end
        @(negedge clk);
        req_vld = '0; #1;
        checks++; if (srv_cmd_vld !== 1'b1 || srv_cmd_data !== 8'h99) begin errors++; $display("FAIL rmid_cmd got=%b/%h exp=1/99", srv_cmd_vld, srv_cmd_data); end
        @(negedge clk); #1;
        checks++; if (srv_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rmid_in_rsp got=%b exp=1", srv_rsp_rdy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; srv_rsp_vld = 1'b1; srv_rsp_data = 8'h9A; #1;
        checks++; if (all_outs !== 27'd0) begin errors++; $display("FAIL rmid_outs got=%h exp=0", all_outs); end
        @(negedge clk);
        srv_rsp_vld = 1'b0; #1;
        checks++; if (rsp_vld !== 4'b0 || srv_cmd_vld !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got=%b/%b exp=0000/0", rsp_vld, srv_cmd_vld); end
        @(negedge clk);
        req_vld = 4'hF; #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL rmid_ptr got=%b exp=0001", req_rdy); end
        @(negedge clk);
        do_reset();
    endtask

`ifdef CMD_RSP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic seen;
        do_reset();
        @(negedge clk);
        req_vld = 4'b0001; req_data = 32'h0000_0055; srv_cmd_rdy = 1'b1;
        @(negedge clk);
        req_vld = '0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk); #1;
            if (rsp_vld === 4'b0001) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL tmo_no_rsp got=0 exp=1"); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 8'h00) begin errors++; $display("FAIL tmo_err got=%b/%h exp=1/00", rsp_err, rsp_data); end
        rsp_rdy = 4'b0001; req_vld = 4'b0010; req_data = 32'h0000_5600;
        @(negedge clk);
        rsp_rdy = '0; #1;
        checks++; if (req_rdy !== 4'b0010 || srv_rsp_rdy !== 1'b1) begin errors++; $display("FAIL tmo_drain_idle got=%b/%b exp=0010/1", req_rdy, srv_rsp_rdy); end
        @(negedge clk);
        req_vld = '0; #1;
        checks++; if (srv_cmd_vld !== 1'b0) begin errors++; $display("FAIL tmo_cmd_held got=%b exp=0", srv_cmd_vld); end
        @(negedge clk); #1;
        checks++; if (srv_cmd_vld !== 1'b0) begin errors++; $display("FAIL tmo_cmd_held2 got=%b exp=0", srv_cmd_vld); end
        srv_rsp_vld = 1'b1; srv_rsp_data = 8'hAA;
        @(negedge clk);
        srv_rsp_vld = 1'b0; #1;
        checks++; if (srv_cmd_vld !== 1'b1 || srv_rsp_rdy !== 1'b0) begin errors++; $display("FAIL tmo_after_drain got=%b/%b exp=1/0", srv_cmd_vld, srv_rsp_rdy); end
        @(negedge clk);
        srv_rsp_vld = 1'b1; srv_rsp_data = 8'h57;
        @(negedge clk);
        srv_rsp_vld = 1'b0; rsp_rdy = 4'b0010; #1;
        checks++; if (rsp_vld !== 4'b0010 || rsp_data !== 8'h57 || rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_next_rsp got=%b/%h/%b exp=0010/57/0", rsp_vld, rsp_data, rsp_err); end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_rsp_hold();
        test_drop();
        test_reset_mid();
`ifdef CMD_RSP_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmd_rsp_arbiter.md
# cmd_rsp_arbiter

Round-robin arbiter and sequencer that shares one command/response server between `N_REQ` requesters. Each requester issues a command with a valid/ready handshake and receives exactly one response with a valid/ready handshake. The block runs one transaction at a time and forwards each command to the server. It waits for the server's response and returns it to the granted requester before it arbitrates again. It sits between the requester-side handshake FSMs and a single shared server port.

## Interface
- `N_REQ`, 4: number of requesters, 2..16
- `DATA_W`, 8: command and response payload width
- `TIMEOUT`, 255: response watchdog limit in cycles; used only with the macro below
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_vld`  in  N_REQ  per-requester command valid
- `req_rdy`  out  N_REQ  per-requester command accept; one-hot or zero
- `req_data`  in  N_REQ*DATA_W  commands; requester i occupies bits [i*DATA_W +: DATA_W]
- `rsp_vld`  out  N_REQ  per-requester response valid; one-hot or zero
- `rsp_rdy`  in  N_REQ  per-requester response accept
- `rsp_data`  out  DATA_W  response payload, shared by all requesters
- `rsp_err`  out  1  response is a timeout error
- `srv_cmd_vld`  out  1  command valid to server
- `srv_cmd_rdy`  in  1  server accepts command
- `srv_cmd_data`  out  DATA_W  command to server
- `srv_rsp_vld`  in  1  server response valid
- `srv_rsp_rdy`  out  1  block accepts server response
- `srv_rsp_data`  in  DATA_W  server response payload

## Operation
- **States:** IDLE, CMD, RSP, RET. Registered state: `grant` index, `ptr` priority pointer, command register, response register, error bit.
- **IDLE:**
  - Winner is the first i with `req_vld[i]=1`, scanning from `ptr` upward modulo N_REQ.
  - `req_rdy[winner]=1` combinationally; all other `req_rdy` bits are 0.
  - In the same cycle: latch `req_data` slice into the command register, set `grant=winner`, go to CMD.
  - If no request is pending, stay in IDLE.
- **CMD:** `srv_cmd_vld=1` and `srv_cmd_data` = command register, held stable. On `srv_cmd_rdy=1`, go to RSP.
- **RSP:** `srv_rsp_rdy=1`. On `srv_rsp_vld=1`, latch `srv_rsp_data`, clear the error bit, go to RET.
- **RET:**
  - `rsp_vld[grant]=1`, `rsp_data` = response register, `rsp_err` = error bit.
  - On `rsp_rdy[grant]=1`: set `ptr=(grant+1) mod N_REQ` and go to IDLE.
  - `rsp_rdy` bits of non-granted requesters are ignored.
- **Handshake rules:**
  - `req_rdy` is 0 outside IDLE.
  - `srv_rsp_rdy` is 0 outside RSP, except while draining (see Configuration). A server response raised during CMD is not accepted until RSP.
  - Requester data sampled only on the accept cycle.
- **Reset:** state IDLE, `ptr=0`, `grant=0`, registers 0. All outputs 0: `req_rdy`, `rsp_vld`, `rsp_data`, `rsp_err`, `srv_cmd_vld`, `srv_cmd_data`, `srv_rsp_rdy`.
- **Boundary conditions:**
  - All requesters valid continuously: grants go 0,1,2,…,N_REQ-1,0; `ptr` wraps.
  - A requester that drops `req_vld` before acceptance gets no grant and no response.
  - Reset mid-transaction abandons it: no response delivered, server port idles from the next cycle.
  - Requester i re-requesting while its response is pending: not accepted until after RET.

## Timing
- Minimum latency, requester accept (cycle 0) to `rsp_vld` asserted: 3 cycles. Cycle 1 has `srv_cmd_vld`, cycle 2 has `srv_rsp_rdy`, cycle 3 has `rsp_vld`.
- Each server stall cycle adds exactly one cycle.
- Peak throughput: one transaction per 4 cycles.
- `req_rdy` depends combinationally on `req_vld`, `state` and `ptr`. Every other output is a function of registered state only.

## Configuration
- **`CMD_RSP_ARB_TIMEOUT_EN` defined:**
  - A counter starts at 0 on entry to RSP and increments each RSP cycle without `srv_rsp_vld`.
  - When it reaches `TIMEOUT`, go to RET with `rsp_err=1` and `rsp_data=0`, and set the `drain` flag.
  - While `drain=1`: `srv_rsp_rdy=1` in all states, and CMD does not assert `srv_cmd_vld`.
  - The first accepted `srv_rsp_vld` beat is discarded and clears `drain`.
- **Macro undefined:** no counter or drain logic; RSP waits indefinitely; `rsp_err` is tied 0.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0; `req_vld=0001`, `req_data[0]=0x5A`, server always ready and echoing cmd+1 -> `srv_cmd_data=0x5A` at cycle 1, `rsp_vld=0001` with `rsp_data=0x5B` at cycle 3.
- `req_vld=1111` held, instant server and requesters -> grant order 0,1,2,3,0, one transaction every 4 cycles.
- Server holds `srv_cmd_rdy=0` 3 cycles and `srv_rsp_vld=0` 2 cycles -> `srv_cmd_data` stable throughout; `rsp_vld` at cycle 8.
- Requester 2 holds `rsp_rdy=0` 4 cycles while requester 1 is valid -> `req_rdy` stays 0; requester 1 is granted only after requester 2's handshake.
- `rst` pulsed while in RSP -> next cycle all outputs 0, no `rsp_vld`, `ptr=0`.
- With `CMD_RSP_ARB_TIMEOUT_EN`, `TIMEOUT=8`, server silent -> `rsp_vld` with `rsp_err=1`, `rsp_data=0`. A late server response is discarded, and the next command is issued only afterwards.
